gate_sweep_checker: RTL

//   Self-checking stimulus stage for 2-input gate cells (AND/OR/XOR/...).

---
 rtl/gate_sweep_checker_if.sv | 23 ++
 rtl/gate_sweep_checker.sv | 80 ++++++++
 2 files changed

// File: rtl/gate_sweep_checker_if.sv
// Stimulus/response bundle between the sweep checker and its controller and gate under test.
// The slave side is the checker: it takes start and y, and drives the gate inputs and the results.
interface gate_sweep_checker_if;
  logic       start;
  logic       y;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_cnt;
  logic [3:0] err_map;

  modport master (
    output start, y,
    input  a, b, busy, done, pass, err_cnt, err_map
  );

  modport slave (
    input  start, y,
    output a, b, busy, done, pass, err_cnt, err_map
  );
endinterface

// File: rtl/gate_sweep_checker.sv
// Sweeps a 2-input gate through 00..11, checks y against TRUTH after HOLD_CYCLES per vector.
// Sweep takes 4*HOLD_CYCLES cycles from start; start is ignored while busy, with no queuing.
module gate_sweep_checker #(
  parameter int         HOLD_CYCLES = 10,
  parameter logic [3:0] TRUTH       = 4'b1000
) (
  input logic            clk,
  input logic            rst_n,
  gate_sweep_checker_if.slave sw
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  state_t        state;
  logic [1:0]    vec;
  logic [CW-1:0] hold_cnt;
  logic          busy_q;
  logic          done_q;
  logic [2:0]    err_cnt_q;
  logic [3:0]    err_map_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vec       <= 2'd0;
      hold_cnt  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_cnt_q <= 3'd0;
      err_map_q <= 4'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (sw.start) begin
            state     <= HOLD;
            vec       <= 2'd0;
            hold_cnt  <= '0;
            err_cnt_q <= 3'd0;
            err_map_q <= 4'd0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        HOLD: begin
          if (hold_cnt == LAST) begin
            hold_cnt <= '0;
            // y is only looked at here, so glitches between compare edges never count
            if (sw.y != TRUTH[vec]) begin
              err_map_q[vec] <= 1'b1;
              err_cnt_q      <= err_cnt_q + 3'd1;
            end
            if (vec == 2'd3) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              vec <= vec + 2'd1;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // vec is a register, so a/b are registered and hold 1,1 in DONE
  assign sw.a       = vec[1];
  assign sw.b       = vec[0];
  assign sw.busy    = busy_q;
  assign sw.done    = done_q;
  assign sw.pass    = done_q && (err_cnt_q == 3'd0);
  assign sw.err_cnt = err_cnt_q;
  assign sw.err_map = err_map_q;

endmodule
